// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU datapath and the sequential divider that
// sits beside it.
//   divu_state_t : divider FSM states (DIVU_IDLE, DIVU_RUN, DIVU_DONE)
//   DIVU_WIDTH   : default operand / result width
//   divu_cnt_w() : width of the divider step counter for a given data width
package alu_pkg;

    typedef enum logic [1:0] {
        DIVU_IDLE = 2'd0,
        DIVU_RUN  = 2'd1,
        DIVU_DONE = 2'd2
    } divu_state_t;

    localparam int DIVU_WIDTH = 32;

    // The counter must be able to represent 0..width.
    function automatic int divu_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divu_step.sv
// divu_step
// One combinational restoring-division step.
// Parameters:
//   WIDTH        : operand width
// Ports:
//   rem_in       in  WIDTH    low bits of the current partial remainder
//   dividend_msb in  1        next dividend bit shifted into the remainder
//   divisor      in  WIDTH    divisor
//   rem_out      out WIDTH+1  partial remainder after this step
//   q_bit        out 1        quotient bit produced by this step
module divu_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] prem;
    logic [WIDTH:0] diff;
    logic           borrow;

    assign prem = {rem_in, dividend_msb};

    // The extra top bit of the widened subtraction is the borrow-out, the
    // same decision the ALU's unsigned set-less-than uses: borrow means
    // prem < divisor, so the divisor does not fit and prem is kept.
    assign {borrow, diff} = {1'b0, prem} - {2'b00, divisor};

    assign q_bit   = ~borrow;
    assign rem_out = borrow ? prem : diff;

endmodule

// File: rtl/divu_seq.sv
// divu_seq
// Multi-cycle unsigned restoring divider, one compare/subtract step per
// cycle, launched by a start pulse and finishing with a one-cycle done strobe.
// Configuration macro:
//   DIVU_EARLY_DZ_EN : when defined, a divide by zero skips the iterations
//                      and goes straight to DONE with the same result.
// Parameters:
//   WIDTH : operand, quotient and remainder width (>= 2)
// Ports:
//   clk   in  1      rising-edge clock
//   rst   in  1      asynchronous active-high reset
//   start in  1      launch request, honoured only while busy = 0
//   A     in  WIDTH  dividend, captured on an accepted start
//   B     in  WIDTH  divisor, captured on an accepted start
//   busy  out 1      division in progress
//   done  out 1      one-cycle strobe, Q/R/dz valid
//   Q     out WIDTH  quotient, held until the next accepted start completes
//   R     out WIDTH  remainder, held likewise
//   dz    out 1      divide-by-zero flag, valid with Q/R
module divu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DIVU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             dz
);

    localparam int CNT_W = divu_cnt_w(WIDTH);

    divu_state_t      state;
    logic [WIDTH-1:0] dq_shift;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   rem;
    logic [CNT_W-1:0] cnt;
    logic             dz_op;

    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] quot_next;
    logic             accept;
    logic             last_step;
    logic             unused_rem_msb;

    // The top bit of the partial remainder is always zero between steps,
    // so only the low WIDTH bits feed the next step.
    assign unused_rem_msb = rem[WIDTH];

    divu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in       (rem[WIDTH-1:0]),
        .dividend_msb (dq_shift[WIDTH-1]),
        .divisor      (divisor),
        .rem_out      (rem_next),
        .q_bit        (q_bit)
    );

    // The dividend and quotient share one shift register: each step consumes
    // the dividend MSB and the new quotient bit enters at the LSB, so after
    // WIDTH steps the register holds exactly the quotient.
    assign quot_next = {dq_shift[WIDTH-2:0], q_bit};
    assign accept    = start && (state != DIVU_RUN);
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    // Status outputs are decodes of the state register only, so nothing
    // combinational reaches them from the inputs.
    assign busy = (state == DIVU_RUN);
    assign done = (state == DIVU_DONE);

    // FSM, iteration datapath and result registers. Results are written only
    // on the edge entering DONE so they stay stable through a following run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DIVU_IDLE;
            dq_shift <= '0;
            divisor  <= '0;
            rem      <= '0;
            cnt      <= '0;
            dz_op    <= 1'b0;
            Q        <= '0;
            R        <= '0;
            dz       <= 1'b0;
        end else begin
            case (state)
                DIVU_IDLE, DIVU_DONE: begin
                    if (accept) begin
                        dq_shift <= A;
                        divisor  <= B;
                        rem      <= '0;
                        cnt      <= '0;
                        dz_op    <= (B == '0);
`ifdef DIVU_EARLY_DZ_EN
                        if (B == '0) begin
                            state <= DIVU_DONE;
                            Q     <= '1;
                            R     <= A;
                            dz    <= 1'b1;
                        end else begin
                            state <= DIVU_RUN;
                        end
`else
                        state <= DIVU_RUN;
`endif
                    end else begin
                        state <= DIVU_IDLE;
                    end
                end
                DIVU_RUN: begin
                    rem      <= rem_next;
                    dq_shift <= quot_next;
                    cnt      <= cnt + 1'b1;
                    if (last_step) begin
                        state <= DIVU_DONE;
                        Q     <= quot_next;
                        R     <= rem_next[WIDTH-1:0];
                        dz    <= dz_op;
                    end
                end
                default: begin
                    state <= DIVU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divu_seq.sv
// tb_divu_seq
// Self-checking bench for divu_seq (WIDTH = 32). Expected results come from
// plain integer division; expected latency follows DIVU_EARLY_DZ_EN.
module tb_divu_seq;

    localparam int W = 32;
`ifdef DIVU_EARLY_DZ_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         dz;

    int errors;
    int checks;

    divu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned division, divide by zero gives all ones / A.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    function automatic int ref_lat(input logic [W-1:0] b);
        return (EARLY && b == 0) ? 1 : W + 1;
    endfunction

    // Pulse start for one edge; returns in cycle k+1 (at a negedge).
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Launch, then count cycles until done (bounded). first_busy is busy in cycle k+1.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic first_busy);
        launch(a, b);
        first_busy = busy;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, dz} !== 3'b000 || Q !== '0 || R !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b dz=%b Q=%h R=%h expected all 0",
                     busy, done, dz, Q, R);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic_timing();
        launch(32'd100, 32'd7);
        for (int c = 1; c <= W + 1; c++) begin
            if (c > 1) @(negedge clk);
            checks++;
            if (busy !== (c <= W) || done !== (c == W + 1)) begin
                errors++;
                $display("[TB] FAIL timing_cycle%0d: got busy=%b done=%b expected busy=%b done=%b",
                         c, busy, done, c <= W, c == W + 1);
            end
        end
        checks++;
        if (Q !== 32'd14 || R !== 32'd2 || dz !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_result: got Q=%0d R=%0d dz=%b expected Q=14 R=2 dz=0", Q, R, dz);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (Q !== 32'd14 || R !== 32'd2 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_after_done: got Q=%0d R=%0d done=%b busy=%b expected 14 2 0 0",
                     Q, R, done, busy);
        end
    endtask

    task automatic test_extremes();
        logic [W-1:0] a_tab [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd5};
        logic [W-1:0] b_tab [4] = '{32'd1, 32'hFFFF_FFFF, 32'd10, 32'd0};
        logic [W-1:0] eq, er;
        logic ez, fb;
        int lat;
        for (int i = 0; i < 4; i++) begin
            ref_div(a_tab[i], b_tab[i], eq, er, ez);
            run_op(a_tab[i], b_tab[i], lat, fb);
            checks++;
            if (lat !== ref_lat(b_tab[i]) || fb !== (ref_lat(b_tab[i]) > 1)) begin
                errors++;
                $display("[TB] FAIL extreme%0d_latency: got lat=%0d busy1=%b expected lat=%0d busy1=%b",
                         i, lat, fb, ref_lat(b_tab[i]), ref_lat(b_tab[i]) > 1);
            end
            checks++;
            if (Q !== eq || R !== er || dz !== ez) begin
                errors++;
                $display("[TB] FAIL extreme%0d_result: got Q=%h R=%h dz=%b expected Q=%h R=%h dz=%b",
                         i, Q, R, dz, eq, er, ez);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic fb;
        launch(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        // Cycle 10: a start while busy must be ignored.
        start = 1'b1;
        A     = 32'd9;
        B     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        lat = 11;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== W + 1 || Q !== 32'd14 || R !== 32'd2) begin
            errors++;
            $display("[TB] FAIL ignored_start: got lat=%0d Q=%0d R=%0d expected lat=%0d Q=14 R=2",
                     lat, Q, R, W + 1);
        end
        // Start held during the DONE cycle is accepted immediately.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fb  = busy;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (fb !== 1'b1 || lat !== W + 1 || Q !== 32'd3 || R !== 32'd0 || dz !== 1'b0) begin
            errors++;
            $display("[TB] FAIL back_to_back: got busy1=%b lat=%0d Q=%0d R=%0d dz=%b expected 1 %0d 3 0 0",
                     fb, lat, Q, R, dz, W + 1);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic fb;
        launch(32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, dz} !== 3'b000 || Q !== '0 || R !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_run: got busy=%b done=%b dz=%b Q=%h R=%h expected all 0",
                     busy, done, dz, Q, R);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd1000, 32'd3, lat, fb);
        checks++;
        if (lat !== W + 1 || Q !== 32'd333 || R !== 32'd1) begin
            errors++;
            $display("[TB] FAIL after_reset_div: got lat=%0d Q=%0d R=%0d expected %0d 333 1",
                     lat, Q, R, W + 1);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eq, er;
        logic ez, fb;
        int lat;
        for (int i = 0; i < 24; i++) begin
            a = $urandom();
            if ($urandom_range(0, 1) == 0) a = a >> $urandom_range(0, 31);
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = $urandom() >> $urandom_range(0, 31);
                default: b = $urandom();
            endcase
            ref_div(a, b, eq, er, ez);
            run_op(a, b, lat, fb);
            checks++;
            if (lat !== ref_lat(b) || Q !== eq || R !== er || dz !== ez) begin
                errors++;
                $display("[TB] FAIL random%0d A=%h B=%h: got lat=%0d Q=%h R=%h dz=%b expected lat=%0d Q=%h R=%h dz=%b",
                         i, a, b, lat, Q, R, dz, ref_lat(b), eq, er, ez);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic_timing();
        test_extremes();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
